// File: rtl/sp_conv_if.sv
// rtl/sp_conv_if.sv - byte-in / word-out handshake bundle for sp_conv (blk_last present under SPC_BLK_TAG_EN)
interface sp_conv_if #(
    parameter int DW = 8,
    parameter int NB = 4
);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [DW-1:0]    din;
    logic             din_vld;
    logic             din_rdy;
    logic             flush;
    logic [DW*NB-1:0] pdout;
    logic             pdout_vld;
    logic             pdout_rdy;
    logic [CW-1:0]    byte_cnt;
`ifdef SPC_BLK_TAG_EN
    logic             blk_last;
`endif

    // Producer of bytes / consumer of words (the environment side)
    modport master (
        output din, din_vld, flush, pdout_rdy,
        input  din_rdy, pdout, pdout_vld, byte_cnt
`ifdef SPC_BLK_TAG_EN
        , input blk_last
`endif
    );

    // The packer itself
    modport slave (
        input  din, din_vld, flush, pdout_rdy,
        output din_rdy, pdout, pdout_vld, byte_cnt
`ifdef SPC_BLK_TAG_EN
        , output blk_last
`endif
    );
endinterface

// File: rtl/sp_conv.sv
// rtl/sp_conv.sv - serial-to-parallel byte packer, MSB-first; SPC_BLK_TAG_EN adds the blk_last word tag
module sp_conv #(
    parameter int DW = 8,
    parameter int NB = 4
) (
    input  logic    clk,
    input  logic    rst,
    sp_conv_if.slave bus
);
    localparam int            CW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int            PW   = DW * (NB - 1);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    partial_q, partial_d;
    logic [DW*NB-1:0] pdout_q, pdout_d;
    logic             pdout_vld_q, pdout_vld_d;
    logic             din_rdy;
    logic             accept;
    logic             handoff;
    logic             load;

`ifdef SPC_BLK_TAG_EN
    logic [1:0]       wcnt_q, wcnt_d;
    logic             blk_last_q, blk_last_d;
`endif

    // Only a last byte that would overwrite an un-handed-off word has to wait
    assign din_rdy = !rst && !bus.flush && (cnt_q != LAST || !pdout_vld_q || bus.pdout_rdy);
    assign accept  = bus.din_vld && din_rdy;
    assign handoff = pdout_vld_q && bus.pdout_rdy;
    assign load    = accept && (cnt_q == LAST);

    // Next-state: byte slotting, word load, handoff and flush
    always_comb begin
        cnt_d       = cnt_q;
        partial_d   = partial_q;
        pdout_d     = pdout_q;
        pdout_vld_d = pdout_vld_q;

        if (handoff) begin
            pdout_vld_d = 1'b0;
        end

        if (bus.flush) begin
            cnt_d     = '0;
            partial_d = '0;
        end else if (load) begin
            pdout_d     = {partial_q, bus.din};
            pdout_vld_d = 1'b1;
            cnt_d       = '0;
            partial_d   = '0;
        end else if (accept) begin
            for (int i = 0; i < NB - 1; i++) begin
                if (cnt_q == CW'(i)) begin
                    partial_d[DW*(NB-1-i)-1 -: DW] = bus.din;
                end
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            partial_q   <= '0;
            pdout_q     <= '0;
            pdout_vld_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            partial_q   <= partial_d;
            pdout_q     <= pdout_d;
            pdout_vld_q <= pdout_vld_d;
        end
    end

`ifdef SPC_BLK_TAG_EN
    // Word position inside the 128-bit block; tag rides along with the loaded word
    always_comb begin
        wcnt_d     = wcnt_q;
        blk_last_d = blk_last_q;
        if (bus.flush) begin
            wcnt_d = '0;
        end else if (load) begin
            blk_last_d = (wcnt_q == 2'd3);
            wcnt_d     = wcnt_q + 2'd1;
        end
    end

    // Tag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q     <= '0;
            blk_last_q <= 1'b0;
        end else begin
            wcnt_q     <= wcnt_d;
            blk_last_q <= blk_last_d;
        end
    end

    assign bus.blk_last = blk_last_q;
`endif

    assign bus.din_rdy   = din_rdy;
    assign bus.pdout     = pdout_q;
    assign bus.pdout_vld = pdout_vld_q;
    assign bus.byte_cnt  = cnt_q;
endmodule

// File: tb/tb_sp_conv.sv
// tb/tb_sp_conv.sv - scoreboard bench for sp_conv
module tb_sp_conv;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   stalls;
    int   tb_w;
    logic [31:0] exp_q[$];
    bit          exp_bl_q[$];

    sp_conv_if #(.DW(8), .NB(4)) bus ();

    sp_conv #(.DW(8), .NB(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handoff is popped against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.pdout_vld && bus.pdout_rdy) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got 0x%0h with empty scoreboard", bus.pdout);
            end else begin
                logic [31:0] ew;
                bit          eb;
                ew = exp_q.pop_front();
                eb = exp_bl_q.pop_front();
                chk("word", {32'd0, bus.pdout}, {32'd0, ew});
`ifdef SPC_BLK_TAG_EN
                chk("blk_last", {63'd0, bus.blk_last}, {63'd0, eb});
`else
                if (eb) begin end
`endif
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.din     = b;
        bus.din_vld = 1'b1;
        @(negedge clk);
        while (!bus.din_rdy && n < 50) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", b);
        end
        @(posedge clk);
        #1;
        bus.din_vld = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w);
        exp_bl_q.push_back(tb_w == 3);
        tb_w = (tb_w + 1) % 4;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        push_word(w);
    endtask

    task automatic do_flush();
        bus.flush   = 1'b1;
        bus.din     = 8'h77;
        bus.din_vld = 1'b1;
        @(negedge clk);
        chk("flush_din_rdy", {63'd0, bus.din_rdy}, 64'd0);
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.din_vld = 1'b0;
        tb_w        = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        stalls        = 0;
        tb_w          = 0;
        rst           = 1'b1;
        bus.din       = '0;
        bus.din_vld   = 1'b0;
        bus.flush     = 1'b0;
        bus.pdout_rdy = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_din_rdy", {63'd0, bus.din_rdy}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pdout", {32'd0, bus.pdout}, 64'd0);
        chk("rst_vld", {63'd0, bus.pdout_vld}, 64'd0);
        chk("rst_byte_cnt", {62'd0, bus.byte_cnt}, 64'd0);
        chk("rst_din_rdy_after", {63'd0, bus.din_rdy}, 64'd1);

        // First word, valid for exactly one cycle
        @(posedge clk);
        #1;
        bus.pdout_rdy = 1'b1;
        send_word(32'h00010203);
        chk("w0_vld_1", {63'd0, bus.pdout_vld}, 64'd1);
        chk("w0_pdout", {32'd0, bus.pdout}, 64'h00010203);
        @(posedge clk);
        #1;
        chk("w0_vld_0", {63'd0, bus.pdout_vld}, 64'd0);

        // Backpressure: last byte stalls until the held word is taken
        bus.pdout_rdy = 1'b0;
        send_word(32'h10111213);
        send_byte(8'h14);
        send_byte(8'h15);
        send_byte(8'h16);
        bus.din     = 8'h17;
        bus.din_vld = 1'b1;
        @(negedge clk);
        chk("hold_din_rdy", {63'd0, bus.din_rdy}, 64'd0);
        chk("hold_byte_cnt", {62'd0, bus.byte_cnt}, 64'd3);
        @(negedge clk);
        chk("hold_pdout", {32'd0, bus.pdout}, 64'h10111213);
        chk("hold_vld", {63'd0, bus.pdout_vld}, 64'd1);
        @(posedge clk);
        #1;
        bus.pdout_rdy = 1'b1;
        push_word(32'h14151617);
        @(negedge clk);
        chk("release_din_rdy", {63'd0, bus.din_rdy}, 64'd1);
        @(posedge clk);
        #1;
        bus.din_vld   = 1'b0;
        bus.pdout_rdy = 1'b0;
        chk("swap_vld", {63'd0, bus.pdout_vld}, 64'd1);
        chk("swap_pdout", {32'd0, bus.pdout}, 64'h14151617);
        bus.pdout_rdy = 1'b1;
        @(posedge clk);
        #1;

        // Sustained stream, no stalls
        stalls = 0;
        for (int k = 0; k < 4; k++) begin
            send_word({4'hA, 4'(4*k), 4'hA, 4'(4*k+1), 4'hA, 4'(4*k+2), 4'hA, 4'(4*k+3)});
        end
        chk("stream_stalls", 64'(stalls), 64'd0);
        @(posedge clk);
        #1;

        // Flush discards a partial word
        send_byte(8'h55);
        send_byte(8'h66);
        chk("pre_flush_cnt", {62'd0, bus.byte_cnt}, 64'd2);
        do_flush();
        chk("post_flush_cnt", {62'd0, bus.byte_cnt}, 64'd0);
        send_word(32'h01020304);
        @(posedge clk);
        #1;

        // Reset while a word is held and a partial word is in progress
        bus.pdout_rdy = 1'b0;
        send_word(32'hDEADBEEF);
        void'(exp_q.pop_back());
        void'(exp_bl_q.pop_back());
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_din_rdy", {63'd0, bus.din_rdy}, 64'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        tb_w = 0;
        @(negedge clk);
        chk("rst2_pdout", {32'd0, bus.pdout}, 64'd0);
        chk("rst2_vld", {63'd0, bus.pdout_vld}, 64'd0);
        chk("rst2_byte_cnt", {62'd0, bus.byte_cnt}, 64'd0);
        chk("rst2_din_rdy_after", {63'd0, bus.din_rdy}, 64'd1);
        @(posedge clk);
        #1;
        bus.pdout_rdy = 1'b1;

        // Block tagging: 4 words, then 2 words, flush, 4 more
        for (int k = 0; k < 4; k++) begin
            send_word({4'h0, 4'(4*k), 4'h0, 4'(4*k+1), 4'h0, 4'(4*k+2), 4'h0, 4'(4*k+3)});
        end
        send_word(32'h20212223);
        send_word(32'h24252627);
        do_flush();
        for (int k = 0; k < 4; k++) begin
            send_word({4'h3, 4'(4*k), 4'h3, 4'(4*k+1), 4'h3, 4'(4*k+2), 4'h3, 4'(4*k+3)});
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
